// File: rtl/flash_playback_scheduler.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// flash_playback_scheduler
//
// Purpose: sequences the flash word reader for audio playback. Walks word
// addresses forward or backward between START_ADDR and END_ADDR with
// wrap-around, issues one read per 32-bit word and releases the two 16-bit
// samples of each word, one per sample tick.
//
// Ports:
//   CLK_50M      in   system clock, rising edge
//   reset        in   synchronous, active-low reset
//   sample_tick  in   one-cycle sample-rate strobe
//   play         in   level, 1 = run, 0 = pause
//   direction    in   0 = forward, 1 = backward
//   restart      in   one-cycle pulse, jump to START_ADDR / END_ADDR
//   rd_start     out  one-cycle read request to the flash reader
//   rd_address   out  word address for the flash reader (registered)
//   rd_finish    in   one-cycle pulse, rd_data valid
//   rd_data      in   word returned by the flash reader
//   sample_out   out  current audio sample (registered)
//   sample_valid out  one-cycle pulse when sample_out updates
//   busy         out  high in every state except IDLE
//   underrun     out  sticky, a tick was lost because no word was ready
// -----------------------------------------------------------------------------
module flash_playback_scheduler #(
    parameter int unsigned        ADDR_W     = 23,
    parameter logic [ADDR_W-1:0]  START_ADDR = 23'h000000,
    parameter logic [ADDR_W-1:0]  END_ADDR   = 23'h07FFFF
) (
    input  logic              CLK_50M,
    input  logic              reset,
    input  logic              sample_tick,
    input  logic              play,
    input  logic              direction,
    input  logic              restart,
    output logic              rd_start,
    output logic [ADDR_W-1:0] rd_address,
    input  logic              rd_finish,
    input  logic [31:0]       rd_data,
    output logic [15:0]       sample_out,
    output logic              sample_valid,
    output logic              busy,
    output logic              underrun
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT_RD,
        S_TICK0,
        S_TICK1,
        S_ADVANCE
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       word_q, word_d;
    logic              bwd_order_q, bwd_order_d;     // 1: high halfword first
    logic              pending_q, pending_d;         // restart seen during a read
    logic              pending_dir_q, pending_dir_d; // direction at that restart
    logic [15:0]       sample_q, sample_d;
    logic              valid_q, valid_d;
    logic              underrun_q, underrun_d;
    logic              accept_tick;

    function automatic logic [ADDR_W-1:0] restart_addr(input logic dir);
        return dir ? END_ADDR : START_ADDR;
    endfunction

    function automatic logic [ADDR_W-1:0] step_addr(input logic [ADDR_W-1:0] a,
                                                    input logic dir);
        if (!dir) return (a == END_ADDR)   ? START_ADDR : a + 1'b1;
        else      return (a == START_ADDR) ? END_ADDR   : a - 1'b1;
    endfunction

    assign accept_tick = sample_tick & play;

    always_comb begin
        // NOTE: every variable gets a default first so no path through the
        // case below can leave one unassigned and infer a latch.
        state_d       = state_q;
        addr_d        = addr_q;
        word_d        = word_q;
        bwd_order_d   = bwd_order_q;
        pending_d     = pending_q;
        pending_dir_d = pending_dir_q;
        sample_d      = sample_q;
        valid_d       = 1'b0;
        underrun_d    = underrun_q;

        // A tick arriving while no word is buffered is dropped and flagged;
        // a same-cycle restart takes precedence and clears the flag.
        if (accept_tick && (state_q inside {S_FETCH, S_WAIT_RD, S_ADVANCE}))
            underrun_d = 1'b1;
        if (restart)
            underrun_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (restart) addr_d = restart_addr(direction);
                if (play)    state_d = S_FETCH;
            end

            S_FETCH: begin
                // The request goes out this cycle regardless, so a restart
                // here must wait for the read to come back, as in WAIT_RD.
                state_d = S_WAIT_RD;
                if (restart) begin
                    pending_d     = 1'b1;
                    pending_dir_d = direction;
                end
            end

            S_WAIT_RD: begin
                if (restart) begin
                    pending_d     = 1'b1;
                    pending_dir_d = direction;
                end
                if (rd_finish) begin
                    if (pending_q || restart) begin
                        // Word belongs to the abandoned position: discard it.
                        addr_d    = restart_addr(restart ? direction : pending_dir_q);
                        pending_d = 1'b0;
                        state_d   = S_FETCH;
                    end else begin
                        word_d      = rd_data;
                        bwd_order_d = direction;
                        state_d     = S_TICK0;
                    end
                end
            end

            S_TICK0: begin
                if (restart) begin
                    addr_d  = restart_addr(direction);
                    state_d = S_FETCH;
                end else if (accept_tick) begin
                    sample_d = bwd_order_q ? word_q[31:16] : word_q[15:0];
                    valid_d  = 1'b1;
                    state_d  = S_TICK1;
                end
            end

            S_TICK1: begin
                if (restart) begin
                    addr_d  = restart_addr(direction);
                    state_d = S_FETCH;
                end else if (accept_tick) begin
                    sample_d = bwd_order_q ? word_q[15:0] : word_q[31:16];
                    valid_d  = 1'b1;
                    state_d  = S_ADVANCE;
                end
            end

            S_ADVANCE: begin
                addr_d  = restart ? restart_addr(direction) : step_addr(addr_q, direction);
                state_d = S_FETCH;
            end

            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the values computed before this edge, independent of statement order.
    always_ff @(posedge CLK_50M) begin
        if (!reset) begin
            state_q       <= S_IDLE;
            addr_q        <= START_ADDR;
            word_q        <= '0;
            bwd_order_q   <= 1'b0;
            pending_q     <= 1'b0;
            pending_dir_q <= 1'b0;
            sample_q      <= '0;
            valid_q       <= 1'b0;
            underrun_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            addr_q        <= addr_d;
            word_q        <= word_d;
            bwd_order_q   <= bwd_order_d;
            pending_q     <= pending_d;
            pending_dir_q <= pending_dir_d;
            sample_q      <= sample_d;
            valid_q       <= valid_d;
            underrun_q    <= underrun_d;
        end
    end

    assign rd_start     = (state_q == S_FETCH);
    assign rd_address   = addr_q;
    assign sample_out   = sample_q;
    assign sample_valid = valid_q;
    assign busy         = (state_q != S_IDLE);
    assign underrun     = underrun_q;

endmodule

// File: tb/tb_flash_playback_scheduler.sv
`timescale 1ns/1ps
module tb_flash_playback_scheduler;

    localparam int ADDR_W = 23;
    localparam logic [ADDR_W-1:0] START_A = 23'd0;
    localparam logic [ADDR_W-1:0] END_A   = 23'd3;

    logic              clk = 1'b0;
    logic              reset;
    logic              sample_tick;
    logic              play;
    logic              direction;
    logic              restart;
    logic              rd_start;
    logic [ADDR_W-1:0] rd_address;
    logic              rd_finish;
    logic [31:0]       rd_data;
    logic [15:0]       sample_out;
    logic              sample_valid;
    logic              busy;
    logic              underrun;

    always #10 clk = ~clk;

    flash_playback_scheduler #(
        .ADDR_W     (ADDR_W),
        .START_ADDR (START_A),
        .END_ADDR   (END_A)
    ) dut (
        .CLK_50M      (clk),
        .reset        (reset),
        .sample_tick  (sample_tick),
        .play         (play),
        .direction    (direction),
        .restart      (restart),
        .rd_start     (rd_start),
        .rd_address   (rd_address),
        .rd_finish    (rd_finish),
        .rd_data      (rd_data),
        .sample_out   (sample_out),
        .sample_valid (sample_valid),
        .busy         (busy),
        .underrun     (underrun)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard queues: filled by the stimulus, drained by the monitor.
    logic [15:0]       exp_samples[$];
    logic [ADDR_W-1:0] exp_addrs[$];
    int                sv_cnt = 0;
    int                rs_cnt = 0;

    // Flash reader model.
    logic [31:0]       mem [0:3];
    int                lat = 2;
    int                cnt = 0;
    logic [ADDR_W-1:0] rd_addr_lat = '0;
    logic [ADDR_W-1:0] last_fin_addr = '0;

    initial begin
        mem[0] = 32'h0002_0001;
        mem[1] = 32'h0004_0003;
        mem[2] = 32'h0006_0005;
        mem[3] = 32'h0008_0007;
        rd_finish = 1'b0;
        rd_data   = '0;
        forever begin
            @(posedge clk); #1;
            rd_finish = 1'b0;
            if (cnt > 0) begin
                cnt--;
                if (cnt == 0) begin
                    rd_finish     = 1'b1;
                    rd_data       = mem[rd_addr_lat[1:0]];
                    last_fin_addr = rd_addr_lat;
                    if (busy) check("rd_addr_stable", rd_address, rd_addr_lat);
                end
            end
            if (rd_start) begin
                if (cnt != 0) check("rd_start_while_outstanding", cnt, 0);
                cnt         = lat;
                rd_addr_lat = rd_address;
            end
        end
    end

    // Output monitor, sampled away from the active edge.
    initial begin
        logic [15:0] e;
        forever begin
            @(negedge clk);
            if (sample_valid) begin
                sv_cnt++;
                if (exp_samples.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL unexpected_sample: got 0x%0h, expected no sample", sample_out);
                end else begin
                    e = exp_samples.pop_front();
                    check("sample", sample_out, e);
                    check("sample_src_word", last_fin_addr, (int'(e) - 1) / 2);
                end
            end
            if (rd_start) begin
                rs_cnt++;
                if (exp_addrs.size() > 0) check("rd_address", rd_address, exp_addrs.pop_front());
            end
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1);
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic tick();
        sample_tick = 1'b1;
        cyc(1);
        sample_tick = 1'b0;
    endtask

    task automatic pulse_restart(input logic dir);
        direction = dir;
        restart   = 1'b1;
        cyc(1);
        restart   = 1'b0;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_rd_start"},     rd_start,     0);
        check({tag, "_rd_address"},   rd_address,   START_A);
        check({tag, "_sample_out"},   sample_out,   0);
        check({tag, "_sample_valid"}, sample_valid, 0);
        check({tag, "_busy"},         busy,         0);
        check({tag, "_underrun"},     underrun,     0);
    endtask

    task automatic wait_rd_start(input string name);
        bit found = 1'b0;
        for (int i = 0; i < 12 && !found; i++) begin
            if (rd_start) found = 1'b1;
            else          cyc(1);
        end
        check(name, found, 1);
    endtask

    typedef struct {
        bit          restart;
        bit          dir;
        logic [15:0] exp;
    } vec_t;

    vec_t              vecs [18];
    logic [15:0]       bwd_vals  [9] = '{16'd8, 16'd7, 16'd6, 16'd5, 16'd4, 16'd3, 16'd2, 16'd1, 16'd8};
    logic [ADDR_W-1:0] addr_list [10] = '{23'd0, 23'd1, 23'd2, 23'd3, 23'd0, 23'd3, 23'd2, 23'd1, 23'd0, 23'd3};

    initial begin
        int sv0;
        int rs0;
        int n;

        // Forward wrap then backward wrap, one record per tick.
        for (int i = 0; i < 9; i++) vecs[i] = '{1'b0, 1'b0, (i == 8) ? 16'd1 : 16'(i + 1)};
        for (int i = 0; i < 9; i++) vecs[9 + i] = '{(i == 0), 1'b1, bwd_vals[i]};

        reset = 1'b0; play = 1'b0; direction = 1'b0; restart = 1'b0; sample_tick = 1'b0;
        cyc(3);
        @(negedge clk);
        check_reset_vals("reset");
        cyc(1);
        reset = 1'b1;
        cyc(2);

        // ---- table-driven forward/backward wrap ----
        foreach (addr_list[i]) exp_addrs.push_back(addr_list[i]);
        play = 1'b1;
        for (int i = 0; i < 18; i++) begin
            if (vecs[i].restart) pulse_restart(vecs[i].dir);
            exp_samples.push_back(vecs[i].exp);
            cyc(20);
            tick();
        end
        cyc(20);
        check("table_samples_drained", exp_samples.size(), 0);
        check("table_addrs_drained",   exp_addrs.size(),   0);

        // ---- pause after first sample of word 1 ----
        exp_addrs.push_back(23'd0);
        exp_addrs.push_back(23'd1);
        exp_addrs.push_back(23'd2);
        for (int s = 1; s <= 3; s++) exp_samples.push_back(16'(s));
        pulse_restart(1'b0);
        for (int s = 0; s < 3; s++) begin
            cyc(20);
            tick();
        end
        cyc(3);
        play = 1'b0;
        sv0 = sv_cnt;
        rs0 = rs_cnt;
        repeat (10) begin
            cyc(5);
            tick();
        end
        cyc(3);
        check("pause_no_samples", sv_cnt - sv0, 0);
        check("pause_no_reads",   rs_cnt - rs0, 0);
        check("pause_busy",       busy,         1);
        play = 1'b1;
        exp_samples.push_back(16'd4);
        cyc(2);
        tick();
        cyc(20);
        check("pause_samples_drained", exp_samples.size(), 0);
        check("pause_addrs_drained",   exp_addrs.size(),   0);

        // ---- restart while a slow read is outstanding ----
        lat = 10;
        exp_samples.push_back(16'd5);
        exp_samples.push_back(16'd6);
        exp_addrs.push_back(23'd3);
        tick();
        cyc(20);
        tick();
        wait_rd_start("waitrd_fetch_seen");
        cyc(3);
        exp_addrs.push_back(23'd0);
        pulse_restart(1'b0);
        sv0 = sv_cnt;
        cyc(25);
        check("waitrd_no_samples",    sv_cnt - sv0,      0);
        check("waitrd_refetch_addr0", exp_addrs.size(),  0);
        lat = 2;
        exp_samples.push_back(16'd1);
        tick();
        cyc(5);
        check("waitrd_first_sample_drained", exp_samples.size(), 0);
        check("waitrd_no_underrun",          underrun,           0);

        // ---- underrun: tick every cycle against a slow reader ----
        lat = 6;
        for (int r = 0; r < 2; r++)
            for (int s = 1; s <= 8; s++) exp_samples.push_back(16'(s));
        pulse_restart(1'b0);
        sv0 = sv_cnt;
        sample_tick = 1'b1;
        cyc(40);
        sample_tick = 1'b0;
        cyc(3);
        n = sv_cnt - sv0;
        check("underrun_flag_set",       underrun,              1);
        check("underrun_fewer_samples",  (n > 0) && (n < 40),   1);
        check("underrun_sample_rate",    (n >= 4) && (n <= 10), 1);
        exp_samples.delete();
        cyc(5);
        check("underrun_sticky", underrun, 1);
        // Restart and a lost tick in the same cycle: restart wins.
        direction   = 1'b0;
        restart     = 1'b1;
        sample_tick = 1'b1;
        cyc(1);
        restart     = 1'b0;
        sample_tick = 1'b0;
        @(negedge clk);
        check("underrun_cleared_by_restart", underrun, 0);
        cyc(25);
        lat = 2;

        // ---- reset asserted mid-read ----
        lat = 10;
        pulse_restart(1'b1);
        wait_rd_start("reset_fetch_seen");
        cyc(3);
        check("reset_pre_addr_end", rd_address, END_A);
        reset = 1'b0;
        play  = 1'b0;
        cyc(1);
        @(negedge clk);
        check_reset_vals("midread_reset");
        cyc(1);
        reset = 1'b1;
        sv0 = sv_cnt;
        rs0 = rs_cnt;
        repeat (4) begin
            cyc(4);
            tick();
        end
        cyc(10);
        check("late_finish_no_samples", sv_cnt - sv0, 0);
        check("late_finish_no_reads",   rs_cnt - rs0, 0);
        check("late_finish_idle",       busy,         0);
        check("late_finish_addr",       rd_address,   START_A);
        lat = 2;

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/flash_playback_scheduler.md
# flash_playback_scheduler

Sequences the flash word reader for audio playback. Walks word addresses forward or backward between two bounds with wrap-around, issues one read request per 32-bit word, and releases the two 16-bit samples in each word one per sample tick. Sits between the sample-rate strobe / user controls (play, direction, restart) and the flash reader's start/address/finish handshake.

## Interface
- ADDR_W, 23, flash word-address width
- START_ADDR, 23'h000000, first word address of the sample region
- END_ADDR, 23'h07FFFF, last word address of the sample region (must be ≥ START_ADDR)
- CLK_50M  input  1  system clock; all logic on rising edge
- reset  input  1  synchronous, active-low reset
- sample_tick  input  1  one-cycle sample-rate strobe, already synchronous to CLK_50M
- play  input  1  level; 1 = run, 0 = pause
- direction  input  1  0 = forward, 1 = backward
- restart  input  1  one-cycle pulse; jump to START_ADDR (forward) or END_ADDR (backward)
- rd_start  output  1  one-cycle read request to flash reader
- rd_address  output  ADDR_W  word address for the flash reader
- rd_finish  input  1  one-cycle pulse from flash reader; rd_data valid this cycle
- rd_data  input  32  word returned by flash reader
- sample_out  output  16  current audio sample (registered)
- sample_valid  output  1  one-cycle pulse when sample_out updates
- busy  output  1  high in every state except IDLE
- underrun  output  1  sticky: tick lost because no word was ready

## Operation
- States: IDLE, FETCH, WAIT_RD, TICK0, TICK1, ADVANCE.
- IDLE: entered only from reset. play=1 → FETCH.
- FETCH: rd_start=1 for exactly this cycle → WAIT_RD.
- WAIT_RD: hold rd_address. On rd_finish: latch rd_data into word_reg, latch halfword order from direction → TICK0. Read cannot be aborted.
- TICK0: sample_tick & play → sample_out = first halfword, sample_valid=1 → TICK1.
- TICK1: sample_tick & play → sample_out = second halfword, sample_valid=1 → ADVANCE.
- Halfword order: forward = [15:0] then [31:16]; backward = [31:16] then [15:0].
- ADVANCE: update address using current direction → FETCH.
- Forward: addr==END_ADDR → START_ADDR, else addr+1. Backward: addr==START_ADDR → END_ADDR, else addr−1. No other values ever reach rd_address.
- Pause: play=0 ignores sample_tick in TICK0/TICK1 and holds state; FETCH/WAIT_RD/ADVANCE still complete so the next word is ready on resume.
- restart in TICK0/TICK1/ADVANCE/FETCH: address ← START_ADDR or END_ADDR per direction, underrun cleared, → FETCH next cycle (FETCH re-issues rd_start). In FETCH the current rd_start still completes, so treat as in WAIT_RD.
- restart in WAIT_RD: set restart_pending; on rd_finish discard rd_data, load restart address, clear pending → FETCH.
- restart in IDLE: load restart address; stay until play=1.
- underrun: set when sample_tick & play while in FETCH, WAIT_RD or ADVANCE; tick dropped; cleared only by restart or reset. Same-cycle restart and underrun-tick: restart wins (cleared).

## Timing
- Reset values: state IDLE, rd_start 0, rd_address START_ADDR, sample_out 0, sample_valid 0, busy 0, underrun 0, restart_pending 0.
- rd_address registered, stable from FETCH cycle until rd_finish.
- rd_start high in FETCH cycle only; never high while a read is outstanding.
- sample_out/sample_valid update on the edge after the accepting tick cycle (1-cycle latency).
- TICK1 tick → next rd_start: 2 cycles (ADVANCE, FETCH).
- rd_finish outside WAIT_RD is ignored.
- Reset asserted mid-read: all state cleared; a later stray rd_finish is ignored in IDLE.

## Test plan
- Forward wrap: START=0, END=3, play=1, dir=0, words 0x0002_0001, 0x0004_0003, 0x0006_0005, 0x0008_0007; ticks spaced 20 cycles → samples 1..8 then 1 again; rd_address sequence 0,1,2,3,0.
- Backward wrap: same memory, dir=1, restart pulse → rd_address 3,2,1,0,3; samples 8,7,6,5,…,1,8.
- Pause: play=0 after first sample of word 1 for 10 ticks → no sample_valid, no rd_start; play=1 → next tick emits 4.
- Restart in WAIT_RD: flash delays rd_finish 10 cycles, restart at cycle 3 → data discarded, no sample_valid, next rd_start with rd_address 0.
- Underrun: ticks every cycle with rd_finish latency 6 → underrun rises, sample count < tick count; restart clears it.
- Reset mid-read: reset low during WAIT_RD → all outputs at reset values next edge; late rd_finish produces no sample_valid.
